// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a write FIFO feeding a framing engine that emits
// start, LSB-first payload, optional parity and one or two stop bits.
module uart_tx_fifo #(
    parameter  int CLK_HZ       = 100_000_000,
    parameter  int BIT_RATE     = 9600,
    parameter  int PAYLOAD_BITS = 8,
    parameter  int FIFO_DEPTH   = 16,
    localparam int LVL_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_ready,
    input  logic [1:0]              parity_mode,
    input  logic                    stop_bits2,
    output logic                    uart_txd,
    output logic                    uart_tx_busy,
    output logic [LVL_W-1:0]        fifo_level
);

    localparam int CPB   = CLK_HZ / BIT_RATE;
    localparam int TMR_W = $clog2(CPB);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(PAYLOAD_BITS + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

    // ---------------- FIFO ----------------
    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        level_q;
    logic                    push, pop, fifo_empty;
    logic [PAYLOAD_BITS-1:0] head;

    assign uart_tx_ready = (level_q != LVL_W'(FIFO_DEPTH));
    assign fifo_empty    = (level_q == '0);
    assign push          = uart_tx_en && uart_tx_ready;
    assign head          = mem_q[rd_ptr_q];
    assign fifo_level    = level_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= uart_tx_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      level_q <= level_q + 1'b1;
            else if (pop && !push) level_q <= level_q - 1'b1;
        end
    end

    // ---------------- framer ----------------
    state_e                  state_q, state_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PAYLOAD_BITS-1:0] shr_q, shr_d;
    logic                    par_en_q, par_en_d, par_q, par_d;
    logic                    stop2_q, stop2_d, txd_q, txd_d;
    logic                    tick, load;

    assign tick         = (tmr_q == TMR_W'(CPB - 1));
    assign uart_txd     = txd_q;
    assign uart_tx_busy = (state_q != S_IDLE) || !fifo_empty;

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        cnt_d    = cnt_q;
        shr_d    = shr_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        txd_d    = 1'b1;
        load     = 1'b0;
        pop      = 1'b0;
        if (state_q != S_IDLE) tmr_d = tick ? '0 : tmr_q + 1'b1;
        case (state_q)
            S_IDLE: load = !fifo_empty;
            S_START: begin
                txd_d = 1'b0;
                if (tick) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                txd_d = shr_q[0];
                if (tick) begin
                    shr_d = shr_q >> 1;
                    if (cnt_q == CNT_W'(PAYLOAD_BITS - 1)) begin
                        cnt_d   = '0;
                        state_d = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                txd_d = par_q;
                if (tick) state_d = S_STOP;
            end
            S_STOP: begin
                // cnt_q marks the first of two stop bits; a queued word skips IDLE
                if (tick) begin
                    if (stop2_q && cnt_q == '0) cnt_d = CNT_W'(1);
                    else if (!fifo_empty)       load = 1'b1;
                    else                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (load) begin
            pop      = 1'b1;
            shr_d    = head;
            par_en_d = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_d    = ^head ^ parity_mode[1];
            stop2_d  = stop_bits2;
            state_d  = S_START;
            tmr_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            tmr_q    <= '0;
            cnt_q    <= '0;
            shr_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            cnt_q    <= cnt_d;
            shr_q    <= shr_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            txd_q    <= txd_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: table of single frames on 8- and 5-bit
// instances, then burst, mid-frame config change and mid-frame reset sequences.
module tb_uart_tx_fifo;
    localparam int C = 10;

    logic       clk = 1'b0, resetn = 1'b0;
    logic       en8 = 1'b0, en5 = 1'b0;
    logic [7:0] data8 = '0;
    logic [4:0] data5 = '0;
    logic [1:0] pm = 2'b00;
    logic       s2 = 1'b0;
    logic       rdy8, rdy5, txd8, txd5, busy8, busy5;
    logic [4:0] lvl8, lvl5;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(8), .FIFO_DEPTH(16)) dut8 (
        .clk(clk), .resetn(resetn), .uart_tx_en(en8), .uart_tx_data(data8), .uart_tx_ready(rdy8),
        .parity_mode(pm), .stop_bits2(s2), .uart_txd(txd8), .uart_tx_busy(busy8), .fifo_level(lvl8));

    uart_tx_fifo #(.CLK_HZ(1_000_000), .BIT_RATE(100_000), .PAYLOAD_BITS(5), .FIFO_DEPTH(16)) dut5 (
        .clk(clk), .resetn(resetn), .uart_tx_en(en5), .uart_tx_data(data5), .uart_tx_ready(rdy5),
        .parity_mode(pm), .stop_bits2(s2), .uart_txd(txd5), .uart_tx_busy(busy5), .fifo_level(lvl5));

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic cur_txd(input bit sel);  return sel ? txd5  : txd8;  endfunction
    function automatic logic cur_busy(input bit sel); return sel ? busy5 : busy8; endfunction
    function automatic int   cur_lvl(input bit sel);  return sel ? int'(lvl5) : int'(lvl8); endfunction

    // Called at the negedge after the pop edge; exp holds one char per bit time.
    task automatic check_stream(input bit sel, input string name, input string exp,
                                input int chg_at, input logic [1:0] chg_pm);
        int   n = exp.len() * C;
        int   errs = 0, first = -1;
        logic ft = 1'b0, fb = 1'b0;
        logic e;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == chg_at) pm = chg_pm;
            e = (exp[k / C] == 8'h31);
            if (cur_txd(sel) !== e || cur_busy(sel) !== (k < n - 1)) begin
                errs++;
                if (first < 0) begin first = k; ft = cur_txd(sel); fb = cur_busy(sel); end
            end
        end
        n_chk++;
        if (errs == 0) n_pass++;
        else $display("FAIL %s stream: %0d bad cycles, first at cycle %0d (txd=%b busy=%b), expected bits %s with 0 bad cycles",
                      name, errs, first, ft, fb, exp);
        @(negedge clk);
        chk({name, " idle txd"}, int'(cur_txd(sel)), 1);
        chk({name, " idle busy"}, int'(cur_busy(sel)), 0);
    endtask

    task automatic send(input bit sel, input string name, input logic [7:0] d,
                        input logic [1:0] p, input logic st2, input string exp);
        pm = p; s2 = st2;
        if (sel) begin en5 = 1'b1; data5 = d[4:0]; end
        else     begin en8 = 1'b1; data8 = d;      end
        @(negedge clk);
        en5 = 1'b0; en8 = 1'b0;
        chk({name, " level after write"}, cur_lvl(sel), 1);
        @(negedge clk);
        chk({name, " level after pop"}, cur_lvl(sel), 0);
        chk({name, " txd high at pop"}, int'(cur_txd(sel)), 1);
        pm = ~p; s2 = ~st2;    // frame already latched its configuration
        check_stream(sel, name, exp, -1, 2'b00);
    endtask

    typedef struct {
        bit         sel;
        logic [7:0] d;
        logic [1:0] p;
        logic       s2;
        string      exp;
        string      name;
    } vec_t;

    function automatic vec_t mk(input bit sel, input logic [7:0] d, input logic [1:0] p,
                                input logic st2, input string exp, input string name);
        vec_t v;
        v.sel = sel; v.d = d; v.p = p; v.s2 = st2; v.exp = exp; v.name = name;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int   errs;
        int   busy_errs;
        logic e;
        int   k, f, b;

        vecs[0] = mk(0, 8'h55, 2'b00, 1'b0, "0101010101",   "x55_none_1stop");
        vecs[1] = mk(0, 8'h07, 2'b01, 1'b1, "011100000111", "x07_even_2stop");
        vecs[2] = mk(0, 8'h07, 2'b10, 1'b1, "011100000011", "x07_odd_2stop");
        vecs[3] = mk(0, 8'hA3, 2'b10, 1'b0, "01100010111",  "xA3_odd_1stop");
        vecs[4] = mk(0, 8'h00, 2'b11, 1'b1, "00000000011",  "x00_mode11_2stop");
        vecs[5] = mk(0, 8'h80, 2'b01, 1'b0, "00000000111",  "x80_even_1stop");
        vecs[6] = mk(1, 8'h1F, 2'b10, 1'b0, "01111101",     "p5_x1F_odd");
        vecs[7] = mk(1, 8'h0A, 2'b01, 1'b1, "001010011",    "p5_x0A_even_2stop");

        // reset state
        repeat (2) @(negedge clk);
        chk("reset txd",   int'(txd8),  1);
        chk("reset busy",  int'(busy8), 0);
        chk("reset ready", int'(rdy8),  1);
        chk("reset level", int'(lvl8),  0);
        chk("reset txd p5", int'(txd5), 1);
        resetn = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) send(vecs[i].sel, vecs[i].name, vecs[i].d, vecs[i].p, vecs[i].s2, vecs[i].exp);

        // burst of 18 writes: 17 accepted, frames back to back in order
        pm = 2'b00; s2 = 1'b0;
        errs = 0; busy_errs = 0;
        for (int c = 1; c <= 1705; c++) begin
            en8 = (c <= 18); data8 = 8'(c - 1);
            @(posedge clk);
            @(negedge clk);
            if (c == 17) begin
                chk("burst level full", int'(lvl8), 16);
                chk("burst ready low",  int'(rdy8), 0);
            end
            if (c == 18)  chk("burst 18th dropped", int'(lvl8), 16);
            if (c == 101) chk("burst level before 2nd pop", int'(lvl8), 16);
            if (c == 102) begin
                chk("burst level after 2nd pop", int'(lvl8), 15);
                chk("burst ready back",          int'(rdy8), 1);
            end
            if (c >= 3 && c < 3 + 1700) begin
                k = c - 3; f = k / 100; b = (k % 100) / C;
                if (b == 0)      e = 1'b0;
                else if (b == 9) e = 1'b1;
                else             e = f[b - 1];
                if (txd8 !== e) errs++;
            end
            if (c <= 1704 && busy8 !== (c <= 1701)) busy_errs++;
        end
        en8 = 1'b0;
        chk("burst stream bad cycles", errs, 0);
        chk("burst busy bad cycles", busy_errs, 0);
        chk("burst end level", int'(lvl8), 0);
        chk("burst end txd", int'(txd8), 1);

        // parity change during data bit 3 of frame A only affects frame B
        pm = 2'b00; s2 = 1'b0;
        en8 = 1'b1; data8 = 8'h3C;
        @(negedge clk);
        data8 = 8'h01;
        @(negedge clk);
        en8 = 1'b0;
        chk("cfgchg level", int'(lvl8), 1);
        check_stream(0, "cfgchg", "000111100101000000011", 45, 2'b01);

        // reset during data bit 4 with words queued
        pm = 2'b00; s2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            en8 = 1'b1; data8 = 8'hA1 + 8'(i);
            @(negedge clk);
        end
        en8 = 1'b0;
        chk("rst queued level", int'(lvl8), 4);
        repeat (53) @(negedge clk);
        chk("rst mid data bit4 txd", int'(txd8), 0);
        #2 resetn = 1'b0;
        #1;
        chk("rst async txd",   int'(txd8),  1);
        chk("rst async level", int'(lvl8),  0);
        chk("rst async busy",  int'(busy8), 0);
        chk("rst async ready", int'(rdy8),  1);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        errs = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (txd8 !== 1'b1 || busy8 !== 1'b0 || lvl8 !== 5'd0) errs++;
        end
        chk("rst release quiet cycles bad", errs, 0);
        send(0, "post_reset_x55", 8'h55, 2'b00, 1'b0, "0101010101");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
